// File: rtl/sipo_frame_ctrl.sv
// Flow-controlled serial-to-parallel frame controller: I/Q words are collected
// into a fill bank in SIPO slot order, then handed to a hold bank on a valid/ready port.
module sipo_frame_ctrl #(
  parameter int DATA_WIDTH = 16,
  parameter int REG_NUM    = 8,
  parameter int CNT_W      = $clog2(REG_NUM + 1)
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            s_valid,
  output logic                            s_ready,
  input  logic [2*DATA_WIDTH-1:0]         s_in,
  input  logic                            s_last,
  output logic                            p_valid,
  input  logic                            p_ready,
  output logic [REG_NUM*2*DATA_WIDTH-1:0] p_out,
  output logic [CNT_W-1:0]                p_cnt
);

  localparam int W = 2 * DATA_WIDTH;

  typedef logic [REG_NUM-1:0][W-1:0] bank_t;

  bank_t            fill_q, fill_d;
  bank_t            hold_q, hold_d;
  logic [CNT_W-1:0] wcnt_q, wcnt_d;
  logic [CNT_W-1:0] fill_cnt_q, fill_cnt_d;
  logic [CNT_W-1:0] p_cnt_q, p_cnt_d;
  logic             fill_full_q, fill_full_d;
  logic             p_valid_q, p_valid_d;

  logic             s_hs;
  logic             p_hs;
  logic             hold_free;
  logic             xfer;
  logic             close;
  logic [CNT_W-1:0] slot_idx;

  // s_ready depends only on a flop, so p_ready never reaches it combinationally.
  assign s_ready   = !fill_full_q;
  assign p_valid   = p_valid_q;
  assign p_out     = hold_q;
  assign p_cnt     = p_cnt_q;

  assign s_hs      = s_valid && !fill_full_q;
  assign p_hs      = p_valid_q && p_ready;
  assign hold_free = !p_valid_q || p_ready;
  assign xfer      = fill_full_q && hold_free;
  assign close     = s_hs && (s_last || (wcnt_q == CNT_W'(REG_NUM - 1)));
  assign slot_idx  = CNT_W'(REG_NUM - 1) - wcnt_q;

  always_comb begin
    // NOTE: every _d is defaulted to its current value first, so no path
    // through this block leaves a signal unassigned and no latch is inferred.
    fill_d      = fill_q;
    hold_d      = hold_q;
    wcnt_d      = wcnt_q;
    fill_cnt_d  = fill_cnt_q;
    p_cnt_d     = p_cnt_q;
    fill_full_d = fill_full_q;
    p_valid_d   = p_valid_q;

    // A word is only accepted while the fill bank is open, so it never
    // coincides with a transfer out of that bank.
    if (s_hs) begin
      for (int j = 0; j < REG_NUM; j++) begin
        if (slot_idx == CNT_W'(j)) begin
          fill_d[j] = s_in;
        end
      end
      if (close) begin
        fill_full_d = 1'b1;
        fill_cnt_d  = wcnt_q + CNT_W'(1);
        wcnt_d      = '0;
      end else begin
        wcnt_d      = wcnt_q + CNT_W'(1);
      end
    end

    if (xfer) begin
      hold_d      = fill_q;
      p_cnt_d     = fill_cnt_q;
      p_valid_d   = 1'b1;
      fill_d      = '0;
      fill_full_d = 1'b0;
    end else if (p_hs) begin
      p_valid_d   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: both banks are cleared on reset because unwritten slots of a
    // short frame must read as zero; a partial frame is simply discarded.
    if (!rst_n) begin
      fill_q      <= '0;
      hold_q      <= '0;
      wcnt_q      <= '0;
      fill_cnt_q  <= '0;
      p_cnt_q     <= '0;
      fill_full_q <= 1'b0;
      p_valid_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every flop sampling the
      // pre-edge value, independent of statement order.
      fill_q      <= fill_d;
      hold_q      <= hold_d;
      wcnt_q      <= wcnt_d;
      fill_cnt_q  <= fill_cnt_d;
      p_cnt_q     <= p_cnt_d;
      fill_full_q <= fill_full_d;
      p_valid_q   <= p_valid_d;
    end
  end

endmodule

// File: tb/tb_sipo_frame_ctrl.sv
// Bench for sipo_frame_ctrl: directed scenarios plus random traffic, checked by a
// frame-level reference model feeding a scoreboard queue drained by a monitor.
module tb_sipo_frame_ctrl;

  localparam int DATA_WIDTH = 16;
  localparam int REG_NUM    = 8;
  localparam int CNT_W      = $clog2(REG_NUM + 1);
  localparam int W          = 2 * DATA_WIDTH;
  localparam int FW         = REG_NUM * W;

  typedef logic [W-1:0] word_t;
  typedef struct {
    logic [FW-1:0]    frame;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             s_valid = 1'b0;
  logic             s_ready;
  word_t            s_in = '0;
  logic             s_last = 1'b0;
  logic             p_valid;
  logic             p_ready = 1'b0;
  logic [FW-1:0]    p_out;
  logic [CNT_W-1:0] p_cnt;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int hs_count = 0;
  int last_hs_cyc = 0;

  exp_t  exp_q[$];
  word_t cur[$];

  sipo_frame_ctrl #(.DATA_WIDTH(DATA_WIDTH), .REG_NUM(REG_NUM)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_valid(s_valid), .s_ready(s_ready), .s_in(s_in), .s_last(s_last),
    .p_valid(p_valid), .p_ready(p_ready), .p_out(p_out), .p_cnt(p_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // k-th word of a frame lands in slot REG_NUM-1-k; untouched slots are zero.
  function automatic logic [FW-1:0] build_frame(input word_t words[$]);
    logic [FW-1:0] f = '0;
    foreach (words[k]) f[(REG_NUM-1-k)*W +: W] = words[k];
    return f;
  endfunction

  // Reference model: watches serial handshakes and queues each closed frame.
  always @(negedge clk) begin
    if (!rst_n) begin
      cur.delete();
      exp_q.delete();
    end else if (s_valid && s_ready) begin
      cur.push_back(s_in);
      if (s_last || cur.size() == REG_NUM) begin
        exp_q.push_back('{frame: build_frame(cur), cnt: CNT_W'(cur.size())});
        cur.delete();
      end
    end
  end

  // Monitor: compares each parallel handshake and checks hold stability.
  logic          prev_stall = 1'b0;
  logic [FW-1:0] prev_out = '0;
  logic [CNT_W-1:0] prev_cnt = '0;
  always @(negedge clk) begin
    exp_t e;
    if (prev_stall) begin
      check("hold_valid", FW'(p_valid), FW'(1));
      check("hold_data", p_out, prev_out);
      check("hold_cnt", FW'(p_cnt), FW'(prev_cnt));
    end
    prev_stall = rst_n && p_valid && !p_ready;
    prev_out   = p_out;
    prev_cnt   = p_cnt;
    if (rst_n && p_valid && p_ready) begin
      hs_count++;
      last_hs_cyc = cyc + 1;
      if (exp_q.size() == 0) begin
        check("sb_unexpected_frame", FW'(1), FW'(0));
      end else begin
        e = exp_q.pop_front();
        check("sb_frame", p_out, e.frame);
        check("sb_cnt", FW'(p_cnt), FW'(e.cnt));
      end
    end
  end

  task automatic wait_cycles(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Sends words in order, holding each until accepted; returns the edge of the first accept.
  task automatic send_frame(input word_t words[$], input logic last_on_final,
                            input logic keep_valid, output int first_edge);
    first_edge = -1;
    foreach (words[k]) begin
      int   n = 0;
      logic hs = 1'b0;
      s_valid = 1'b1;
      s_in    = words[k];
      s_last  = last_on_final && (k == words.size() - 1);
      while (!hs && n < 1000) begin
        @(negedge clk); hs = s_ready;
        @(posedge clk); #1; n++;
      end
      if (!hs) check("send_timeout", FW'(0), FW'(1));
      if (first_edge < 0) first_edge = cyc;
    end
    if (!keep_valid) begin
      s_valid = 1'b0;
      s_last  = 1'b0;
    end
  endtask

  task automatic drain();
    int n = 0;
    s_valid = 1'b0;
    s_last  = 1'b0;
    p_ready = 1'b1;
    while ((exp_q.size() != 0 || p_valid) && n < 200) begin wait_cycles(1); n++; end
    check("drain_empty", FW'(exp_q.size()), FW'(0));
    wait_cycles(1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    word_t w[$];
    word_t w2[$];
    int    t0, t_unused, d;

    // Reset state
    wait_cycles(2);
    check("rst_p_valid", FW'(p_valid), FW'(0));
    check("rst_p_out", p_out, FW'(0));
    check("rst_p_cnt", FW'(p_cnt), FW'(0));
    check("rst_s_ready", FW'(s_ready), FW'(1));
    rst_n = 1'b1;
    wait_cycles(1);

    // Full frame 0x1..0x8
    p_ready = 1'b1;
    w = {};
    for (int i = 1; i <= REG_NUM; i++) w.push_back(word_t'(i));
    send_frame(w, 1'b0, 1'b0, t_unused);
    check("full_bubble_s_ready", FW'(s_ready), FW'(0));
    check("full_p_valid_early", FW'(p_valid), FW'(0));
    wait_cycles(1);
    check("full_p_valid", FW'(p_valid), FW'(1));
    check("full_s_ready_back", FW'(s_ready), FW'(1));
    check("full_p_out", p_out, build_frame(w));
    check("full_p_cnt", FW'(p_cnt), FW'(REG_NUM));
    drain();

    // Early last, then a short frame starting again at the top slot
    w = {word_t'('hA), word_t'('hB), word_t'('hC)};
    send_frame(w, 1'b1, 1'b0, t_unused);
    wait_cycles(1);
    check("early_p_out", p_out, build_frame(w));
    check("early_p_cnt", FW'(p_cnt), FW'(3));
    wait_cycles(1);
    w = {word_t'('hD), word_t'('hE)};
    send_frame(w, 1'b1, 1'b0, t_unused);
    wait_cycles(1);
    check("early2_p_out", p_out, build_frame(w));
    check("early2_p_cnt", FW'(p_cnt), FW'(2));
    drain();

    // Backpressure across two frames
    p_ready = 1'b0;
    w = {}; w2 = {};
    for (int i = 0; i < REG_NUM; i++) begin
      w.push_back(word_t'(32'h100 + i));
      w2.push_back(word_t'(32'h200 + i));
    end
    send_frame(w, 1'b0, 1'b0, t_unused);
    wait_cycles(1);
    check("bp_f1_valid", FW'(p_valid), FW'(1));
    send_frame(w2, 1'b0, 1'b0, t_unused);
    wait_cycles(3);
    check("bp_s_ready_low", FW'(s_ready), FW'(0));
    check("bp_f1_held", p_out, build_frame(w));
    p_ready = 1'b1;
    wait_cycles(1);
    check("bp_f2_valid", FW'(p_valid), FW'(1));
    check("bp_f2_out", p_out, build_frame(w2));
    check("bp_s_ready_back", FW'(s_ready), FW'(1));
    drain();

    // Continuous streaming, 4 frames
    d = hs_count;
    for (int f = 0; f < 4; f++) begin
      int fe;
      w = {};
      for (int i = 0; i < REG_NUM; i++) w.push_back(word_t'($urandom));
      send_frame(w, 1'b0, 1'b1, fe);
      if (f == 0) t0 = fe;
    end
    s_valid = 1'b0;
    begin
      int n = 0;
      while (hs_count < d + 4 && n < 100) begin wait_cycles(1); n++; end
    end
    check("stream_frames", FW'(hs_count - d), FW'(4));
    d = last_hs_cyc - t0;
    check("stream_cycles", FW'((d >= 35 && d <= 37) ? 36 : d), FW'(36));
    drain();

    // Reset mid-fill
    w = {};
    for (int i = 0; i < 5; i++) w.push_back(word_t'(32'hDEAD0000 + i));
    send_frame(w, 1'b0, 1'b0, t_unused);
    rst_n = 1'b0;
    wait_cycles(1);
    check("mrst_p_valid", FW'(p_valid), FW'(0));
    check("mrst_p_out", p_out, FW'(0));
    check("mrst_p_cnt", FW'(p_cnt), FW'(0));
    check("mrst_s_ready", FW'(s_ready), FW'(1));
    rst_n = 1'b1;
    w = {};
    for (int i = 0; i < REG_NUM; i++) w.push_back(word_t'(32'h300 + i));
    send_frame(w, 1'b0, 1'b0, t_unused);
    wait_cycles(1);
    check("mrst_clean_frame", p_out, build_frame(w));
    drain();

    // Handshake and transfer on the same edge
    p_ready = 1'b0;
    w = {}; w2 = {};
    for (int i = 0; i < REG_NUM; i++) begin
      w.push_back(word_t'(32'h400 + i));
      w2.push_back(word_t'(32'h500 + i));
    end
    send_frame(w, 1'b0, 1'b0, t_unused);
    wait_cycles(1);
    send_frame(w2, 1'b0, 1'b0, t_unused);
    p_ready = 1'b1;
    wait_cycles(1);
    check("simul_p_valid", FW'(p_valid), FW'(1));
    check("simul_p_out", p_out, build_frame(w2));
    drain();

    // Random traffic
    for (int c = 0; c < 600; c++) begin
      s_valid = ($urandom_range(0, 3) != 0);
      s_in    = word_t'($urandom);
      s_last  = ($urandom_range(0, 4) == 0);
      p_ready = ($urandom_range(0, 2) != 0);
      wait_cycles(1);
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
